// File: rtl/hier_node_bcast.sv
// Hierarchy node: broadcasts one upstream command to NUM_CHILD children and aggregates their done/err completions.
// Optional BUSY timeout is compiled in with `define HIER_NODE_TIMEOUT_EN.
module hier_node_bcast #(
    parameter int NUM_CHILD   = 5,
    parameter int DATA_W      = 32,
    parameter int SEQ_W       = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CHILD-1:0] child_en,
    input  logic                 up_cmd_valid,
    output logic                 up_cmd_ready,
    input  logic [DATA_W-1:0]    up_cmd_data,
    output logic [NUM_CHILD-1:0] dn_cmd_valid,
    input  logic [NUM_CHILD-1:0] dn_cmd_ready,
    output logic [DATA_W-1:0]    dn_cmd_data,
    input  logic [NUM_CHILD-1:0] dn_done,
    input  logic [NUM_CHILD-1:0] dn_err,
    output logic                 up_rsp_valid,
    input  logic                 up_rsp_ready,
    output logic                 up_rsp_err,
    output logic [NUM_CHILD-1:0] up_rsp_err_mask,
    output logic [SEQ_W-1:0]     up_rsp_seq,
    output logic                 up_rsp_timeout,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t               state_reg, state_next;
    logic [NUM_CHILD-1:0] active_reg, active_next;
    logic [NUM_CHILD-1:0] issued_reg, issued_next;
    logic [NUM_CHILD-1:0] done_reg, done_next;
    logic [NUM_CHILD-1:0] err_reg, err_next;
    logic [DATA_W-1:0]    data_reg, data_next;
    logic [SEQ_W-1:0]     seq_reg, seq_next;
    logic                 timeout_reg, timeout_next;
    logic [NUM_CHILD-1:0] done_hit, err_hit;
    logic                 complete;
    logic                 tmo_hit;

    // A done only counts for an active child whose command was issued in an earlier cycle.
    generate
        for (genvar gi = 0; gi < NUM_CHILD; gi++) begin : g_child
            assign done_hit[gi] = (state_reg == BUSY) & dn_done[gi] & active_reg[gi]
                                  & issued_reg[gi] & ~done_reg[gi];
            assign err_hit[gi]  = done_hit[gi] & dn_err[gi];
        end
    endgenerate

    assign complete = ((done_reg | done_hit) == active_reg);

`ifdef HIER_NODE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    // Counter holds k-1 during the k-th BUSY cycle, so the limit is hit on BUSY cycle TIMEOUT_CYC.
    assign tmo_hit = (state_reg == BUSY) && (cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) && !complete;

    always_comb begin
        cnt_next = cnt_reg;
        if (state_reg == IDLE)
            cnt_next = '0;
        else if (state_reg == BUSY)
            cnt_next = cnt_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_next;
    end
`else
    // Feature compiled out: the node never times out.
    assign tmo_hit = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            active_reg  <= '0;
            issued_reg  <= '0;
            done_reg    <= '0;
            err_reg     <= '0;
            data_reg    <= '0;
            seq_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            active_reg  <= active_next;
            issued_reg  <= issued_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            data_reg    <= data_next;
            seq_reg     <= seq_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (up_cmd_valid) state_next = (child_en == '0) ? RESP : BUSY;
            BUSY:    if (complete || tmo_hit) state_next = RESP;
            RESP:    if (up_rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        active_next  = active_reg;
        issued_next  = issued_reg;
        done_next    = done_reg;
        err_next     = err_reg;
        data_next    = data_reg;
        seq_next     = seq_reg;
        timeout_next = timeout_reg;
        case (state_reg)
            IDLE: begin
                if (up_cmd_valid) begin
                    data_next   = up_cmd_data;
                    active_next = child_en;
                    issued_next = '0;
                    done_next   = '0;
                    err_next    = '0;
                end
            end
            BUSY: begin
                issued_next = issued_reg | (active_reg & ~issued_reg & dn_cmd_ready);
                done_next   = done_reg | done_hit;
                err_next    = err_reg | err_hit;
                if (tmo_hit) begin
                    err_next     = err_reg | err_hit | (active_reg & ~done_next);
                    timeout_next = 1'b1;
                end
            end
            RESP: begin
                if (up_rsp_ready) begin
                    seq_next     = seq_reg + 1'b1;
                    timeout_next = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        up_cmd_ready    = (state_reg == IDLE);
        busy            = (state_reg != IDLE);
        dn_cmd_valid    = (state_reg == BUSY) ? (active_reg & ~issued_reg) : '0;
        up_rsp_valid    = (state_reg == RESP);
        up_rsp_err_mask = (state_reg == RESP) ? err_reg : '0;
        up_rsp_err      = |up_rsp_err_mask;
        up_rsp_timeout  = timeout_reg;
        dn_cmd_data     = data_reg;
        up_rsp_seq      = seq_reg;
    end
endmodule

// File: tb/tb_hier_node_bcast.sv
// Directed bench for hier_node_bcast: a cycle table for the basic flows plus hand sequences
// for response stall, sequence wrap, reset mid-BUSY and the optional timeout.
module tb_hier_node_bcast;
    localparam int NC = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [NC-1:0] child_en;
    logic          up_cmd_valid;
    logic          up_cmd_ready;
    logic [31:0]   up_cmd_data;
    logic [NC-1:0] dn_cmd_valid;
    logic [NC-1:0] dn_cmd_ready;
    logic [31:0]   dn_cmd_data;
    logic [NC-1:0] dn_done;
    logic [NC-1:0] dn_err;
    logic          up_rsp_valid;
    logic          up_rsp_ready;
    logic          up_rsp_err;
    logic [NC-1:0] up_rsp_err_mask;
    logic [7:0]    up_rsp_seq;
    logic          up_rsp_timeout;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hier_node_bcast #(.NUM_CHILD(NC), .DATA_W(32), .SEQ_W(8), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .child_en(child_en),
        .up_cmd_valid(up_cmd_valid), .up_cmd_ready(up_cmd_ready), .up_cmd_data(up_cmd_data),
        .dn_cmd_valid(dn_cmd_valid), .dn_cmd_ready(dn_cmd_ready), .dn_cmd_data(dn_cmd_data),
        .dn_done(dn_done), .dn_err(dn_err),
        .up_rsp_valid(up_rsp_valid), .up_rsp_ready(up_rsp_ready), .up_rsp_err(up_rsp_err),
        .up_rsp_err_mask(up_rsp_err_mask), .up_rsp_seq(up_rsp_seq),
        .up_rsp_timeout(up_rsp_timeout), .busy(busy)
    );

    typedef struct {
        logic          cv;
        logic [31:0]   cd;
        logic [NC-1:0] en;
        logic [NC-1:0] rdy;
        logic [NC-1:0] dn;
        logic [NC-1:0] de;
        logic          rr;
        logic          e_cr;
        logic [NC-1:0] e_dv;
        logic [31:0]   e_d;
        logic          e_rv;
        logic [NC-1:0] e_m;
        logic          e_er;
        logic [7:0]    e_sq;
        logic          e_bz;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    task automatic drive(input logic cv, input logic [31:0] cd, input logic [NC-1:0] en,
                         input logic [NC-1:0] rdy, input logic [NC-1:0] dn,
                         input logic [NC-1:0] de, input logic rr);
        up_cmd_valid = cv;
        up_cmd_data  = cd;
        child_en     = en;
        dn_cmd_ready = rdy;
        dn_done      = dn;
        dn_err       = de;
        up_rsp_ready = rr;
    endtask

    logic [7:0] exp_seq;

    initial begin
        // cv, cd, en, rdy, dn, de, rr | e_cr, e_dv, e_d, e_rv, e_m, e_er, e_sq, e_bz
        // all five children, done one cycle after issue: response at cycle 3
        vecs[0]  = '{1'b1, 32'hA5A50001, 5'b11111, 5'b11111, 5'b00000, 5'b00000, 1'b0,
                     1'b1, 5'b00000, 32'h00000000, 1'b0, 5'b00000, 1'b0, 8'd0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 1'b0,
                     1'b0, 5'b11111, 32'hA5A50001, 1'b0, 5'b00000, 1'b0, 8'd0, 1'b1};
        vecs[2]  = '{1'b0, 32'h0, 5'b00000, 5'b00000, 5'b11111, 5'b00000, 1'b0,
                     1'b0, 5'b00000, 32'hA5A50001, 1'b0, 5'b00000, 1'b0, 8'd0, 1'b1};
        vecs[3]  = '{1'b0, 32'h0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1,
                     1'b0, 5'b00000, 32'hA5A50001, 1'b1, 5'b00000, 1'b0, 8'd0, 1'b1};
        // 10101: child 2 stalls four cycles, child 4 errors, spurious done on unissued child 2
        vecs[4]  = '{1'b1, 32'hDEADBEEF, 5'b10101, 5'b10001, 5'b00000, 5'b00000, 1'b0,
                     1'b1, 5'b00000, 32'hA5A50001, 1'b0, 5'b00000, 1'b0, 8'd1, 1'b0};
        vecs[5]  = '{1'b0, 32'h0, 5'b00000, 5'b10001, 5'b00000, 5'b00000, 1'b0,
                     1'b0, 5'b10101, 32'hDEADBEEF, 1'b0, 5'b00000, 1'b0, 8'd1, 1'b1};
        vecs[6]  = '{1'b0, 32'h0, 5'b00000, 5'b00000, 5'b10001, 5'b10000, 1'b0,
                     1'b0, 5'b00100, 32'hDEADBEEF, 1'b0, 5'b00000, 1'b0, 8'd1, 1'b1};
        vecs[7]  = '{1'b0, 32'h0, 5'b00000, 5'b00000, 5'b00100, 5'b00100, 1'b0,
                     1'b0, 5'b00100, 32'hDEADBEEF, 1'b0, 5'b00000, 1'b0, 8'd1, 1'b1};
        vecs[8]  = '{1'b0, 32'h0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0,
                     1'b0, 5'b00100, 32'hDEADBEEF, 1'b0, 5'b00000, 1'b0, 8'd1, 1'b1};
        vecs[9]  = '{1'b0, 32'h0, 5'b00000, 5'b00100, 5'b00000, 5'b00000, 1'b0,
                     1'b0, 5'b00100, 32'hDEADBEEF, 1'b0, 5'b00000, 1'b0, 8'd1, 1'b1};
        vecs[10] = '{1'b0, 32'h0, 5'b00000, 5'b00000, 5'b00100, 5'b00000, 1'b0,
                     1'b0, 5'b00000, 32'hDEADBEEF, 1'b0, 5'b00000, 1'b0, 8'd1, 1'b1};
        vecs[11] = '{1'b0, 32'h0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1,
                     1'b0, 5'b00000, 32'hDEADBEEF, 1'b1, 5'b10000, 1'b1, 8'd1, 1'b1};
        // no children enabled: response one cycle after accept
        vecs[12] = '{1'b1, 32'h00001234, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0,
                     1'b1, 5'b00000, 32'hDEADBEEF, 1'b0, 5'b00000, 1'b0, 8'd2, 1'b0};
        vecs[13] = '{1'b0, 32'h0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1,
                     1'b0, 5'b00000, 32'h00001234, 1'b1, 5'b00000, 1'b0, 8'd2, 1'b1};
        // done/err pulses while IDLE must be ignored
        vecs[14] = '{1'b0, 32'h0, 5'b00000, 5'b00000, 5'b11111, 5'b11111, 1'b0,
                     1'b1, 5'b00000, 32'h00001234, 1'b0, 5'b00000, 1'b0, 8'd3, 1'b0};

        rst = 1'b1;
        drive(1'b0, 32'h0, '0, '0, '0, '0, 1'b0);
        repeat (3) step();
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            chk($sformatf("v%0d_cmd_ready", i), 32'(up_cmd_ready), 32'(vecs[i].e_cr));
            chk($sformatf("v%0d_dn_valid", i), 32'(dn_cmd_valid), 32'(vecs[i].e_dv));
            chk($sformatf("v%0d_dn_data", i), dn_cmd_data, vecs[i].e_d);
            chk($sformatf("v%0d_rsp_valid", i), 32'(up_rsp_valid), 32'(vecs[i].e_rv));
            chk($sformatf("v%0d_err_mask", i), 32'(up_rsp_err_mask), 32'(vecs[i].e_m));
            chk($sformatf("v%0d_err", i), 32'(up_rsp_err), 32'(vecs[i].e_er));
            chk($sformatf("v%0d_seq", i), 32'(up_rsp_seq), 32'(vecs[i].e_sq));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_bz));
            chk($sformatf("v%0d_timeout", i), 32'(up_rsp_timeout), 32'd0);
            $display("vec %0d: cv=%b en=%b rdy=%b done=%b -> dv=%b rv=%b mask=%b seq=%0d",
                     i, vecs[i].cv, vecs[i].en, vecs[i].rdy, vecs[i].dn,
                     dn_cmd_valid, up_rsp_valid, up_rsp_err_mask, up_rsp_seq);
            drive(vecs[i].cv, vecs[i].cd, vecs[i].en, vecs[i].rdy, vecs[i].dn, vecs[i].de, vecs[i].rr);
            step();
        end

        // Response stalled six cycles: fields must hold
        chk("idle_after_spurious_busy", 32'(busy), 32'd0);
        chk("idle_after_spurious_rv", 32'(up_rsp_valid), 32'd0);
        drive(1'b1, 32'h0BADF00D, 5'b00010, 5'b11111, '0, '0, 1'b0);
        step();
        drive(1'b0, 32'h0, '0, 5'b11111, '0, '0, 1'b0);
        step();
        drive(1'b0, 32'h0, '0, '0, 5'b00010, 5'b00010, 1'b0);
        step();
        drive(1'b0, 32'h0, '0, '0, '0, '0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("stall%0d_rv", c), 32'(up_rsp_valid), 32'd1);
            chk($sformatf("stall%0d_mask", c), 32'(up_rsp_err_mask), 32'h02);
            chk($sformatf("stall%0d_err", c), 32'(up_rsp_err), 32'd1);
            chk($sformatf("stall%0d_seq", c), 32'(up_rsp_seq), 32'd3);
            chk($sformatf("stall%0d_data", c), dn_cmd_data, 32'h0BADF00D);
            step();
        end
        up_rsp_ready = 1'b1;
        step();
        up_rsp_ready = 1'b0;
        chk("stall_release_rv", 32'(up_rsp_valid), 32'd0);
        chk("stall_release_seq", 32'(up_rsp_seq), 32'd4);
        $display("txn stall: err_mask=00010 seq=3 held 6 cycles");

        // 256 back-to-back empty commands: sequence wraps 255 -> 0
        exp_seq = 8'd4;
        drive(1'b1, 32'h0, '0, '0, '0, '0, 1'b1);
        for (int k = 0; k < 256; k++) begin
            step();
            chk($sformatf("b2b%0d_rv", k), 32'(up_rsp_valid), 32'd1);
            chk($sformatf("b2b%0d_seq", k), 32'(up_rsp_seq), 32'(exp_seq));
            $display("txn b2b %0d: seq=%0d", k, up_rsp_seq);
            exp_seq = exp_seq + 8'd1;
            step();
        end
        drive(1'b0, 32'h0, '0, '0, '0, '0, 1'b0);
        chk("b2b_end_seq", 32'(up_rsp_seq), 32'(exp_seq));

        // Same-cycle and unissued dones ignored, then reset mid-BUSY
        drive(1'b1, 32'hCAFE0005, 5'b00011, 5'b00001, '0, '0, 1'b0);
        step();
        drive(1'b0, 32'h0, '0, 5'b00001, 5'b00011, '0, 1'b0);
        chk("spur_dv1", 32'(dn_cmd_valid), 32'h03);
        step();
        drive(1'b0, 32'h0, '0, 5'b00010, '0, '0, 1'b0);
        chk("spur_dv2", 32'(dn_cmd_valid), 32'h02);
        step();
        drive(1'b0, 32'h0, '0, '0, 5'b00010, '0, 1'b0);
        chk("spur_dv3", 32'(dn_cmd_valid), 32'h00);
        step();
        drive(1'b0, 32'h0, '0, '0, '0, '0, 1'b0);
        chk("spur_still_busy", 32'(busy), 32'd1);
        chk("spur_no_rsp", 32'(up_rsp_valid), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_cmd_ready", 32'(up_cmd_ready), 32'd1);
        chk("rst_dv", 32'(dn_cmd_valid), 32'd0);
        chk("rst_data", dn_cmd_data, 32'd0);
        chk("rst_rv", 32'(up_rsp_valid), 32'd0);
        chk("rst_mask", 32'(up_rsp_err_mask), 32'd0);
        chk("rst_err", 32'(up_rsp_err), 32'd0);
        chk("rst_seq", 32'(up_rsp_seq), 32'd0);
        chk("rst_timeout", 32'(up_rsp_timeout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        drive(1'b1, 32'h0, '0, '0, '0, '0, 1'b1);
        step();
        drive(1'b0, 32'h0, '0, '0, '0, '0, 1'b1);
        chk("post_rst_rv", 32'(up_rsp_valid), 32'd1);
        chk("post_rst_seq", 32'(up_rsp_seq), 32'd0);
        step();
        chk("post_rst_seq_next", 32'(up_rsp_seq), 32'd1);
        $display("txn reset: mid-BUSY abandoned, first response seq=0");

        // Child 1 never completes
        drive(1'b1, 32'h7777, 5'b00011, 5'b11111, '0, '0, 1'b0);
        step();
        drive(1'b0, 32'h0, '0, 5'b11111, '0, '0, 1'b0);
        step();
        drive(1'b0, 32'h0, '0, '0, 5'b00001, '0, 1'b0);
        step();
        drive(1'b0, 32'h0, '0, '0, '0, '0, 1'b0);
`ifdef HIER_NODE_TIMEOUT_EN
        repeat (13) step();
        chk("tmo_busy_c16", 32'(busy & ~up_rsp_valid), 32'd1);
        step();
        chk("tmo_rv", 32'(up_rsp_valid), 32'd1);
        chk("tmo_flag", 32'(up_rsp_timeout), 32'd1);
        chk("tmo_mask", 32'(up_rsp_err_mask), 32'h02);
        chk("tmo_err", 32'(up_rsp_err), 32'd1);
        up_rsp_ready = 1'b1;
        step();
        up_rsp_ready = 1'b0;
        chk("tmo_clear", 32'(up_rsp_timeout), 32'd0);
        chk("tmo_idle", 32'(busy), 32'd0);
        $display("txn timeout: child 1 timed out, err_mask=00010");
`else
        repeat (40) step();
        chk("notmo_busy", 32'(busy), 32'd1);
        chk("notmo_rv", 32'(up_rsp_valid), 32'd0);
        chk("notmo_flag", 32'(up_rsp_timeout), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        $display("txn no-timeout: node still waiting after 43 BUSY cycles");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hier_node_bcast.md
Name: hier_node_bcast

Overview:
- Parametrised hierarchy node. Broadcasts one upstream command to up to NUM_CHILD child sub-blocks, each with its own valid/ready handshake.
- Collects per-child done/error completions and returns one aggregated response upstream.
- Generalises fixed five-child structural nodes to a configurable child count with real flow control, completion tracking and sequencing.
- Nodes nest: a child port may drive another hier_node_bcast.

Parameters:
- NUM_CHILD, 5, number of child ports (1..32).
- DATA_W, 32, command payload width.
- SEQ_W, 8, response sequence counter width.
- TIMEOUT_CYC, 1024, BUSY-state cycle limit; used only with the optional feature (≥1).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- child_en  in  NUM_CHILD  children participating; sampled only at upstream command accept.
- up_cmd_valid  in  1  upstream command valid.
- up_cmd_ready  out  1  node can accept a command.
- up_cmd_data  in  DATA_W  command payload.
- dn_cmd_valid  out  NUM_CHILD  per-child command valid.
- dn_cmd_ready  in  NUM_CHILD  per-child command ready.
- dn_cmd_data  out  DATA_W  latched payload, shared by all children.
- dn_done  in  NUM_CHILD  per-child single-cycle completion pulse.
- dn_err  in  NUM_CHILD  per-child error; sampled only with its dn_done bit.
- up_rsp_valid  out  1  aggregated response valid.
- up_rsp_ready  in  1  upstream accepts response.
- up_rsp_err  out  1  OR of up_rsp_err_mask.
- up_rsp_err_mask  out  NUM_CHILD  per-child error (or timeout) flags.
- up_rsp_seq  out  SEQ_W  response sequence number.
- up_rsp_timeout  out  1  response produced by timeout.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE and all masks clear.
  - All outputs go to 0: dn_cmd_valid, dn_cmd_data, up_rsp_valid, up_rsp_err, up_rsp_err_mask, up_rsp_seq, up_rsp_timeout, busy.
  - The exception is up_cmd_ready, which is 1 in IDLE after reset.
  - Reset mid-transaction abandons it silently; no response is produced and children see dn_cmd_valid drop.
- State machine IDLE → BUSY → RESP → IDLE.
- IDLE:
  - up_cmd_ready=1.
  - On up_cmd_valid&up_cmd_ready, latch up_cmd_data into dn_cmd_data and child_en into active mask. Clear issued, done and err masks.
  - If active==0, go to RESP directly (response one cycle after accept, err=0). Otherwise go to BUSY.
- BUSY:
  - up_cmd_ready=0.
  - dn_cmd_valid[i] = active[i] & ~issued[i]. issued[i] sets on dn_cmd_valid[i]&dn_cmd_ready[i].
  - Once asserted, valid stays high until that child's handshake; the payload is stable throughout.
  - dn_done[i] counts only if issued[i] was already set at the start of that cycle. A done in the same cycle as its handshake, from an inactive child, or repeated, is ignored.
  - On a counted done: done[i] sets and err[i] |= dn_err[i].
  - When done==active (evaluated on registered state), go to RESP.
- RESP:
  - up_rsp_valid=1 with up_rsp_err_mask=err and up_rsp_err=|err. Held stable until up_rsp_ready.
  - On handshake: up_rsp_seq increments (wraps at 2^SEQ_W−1→0) and state returns to IDLE. up_rsp_valid drops the next cycle.
  - up_rsp_seq shows the number of the current response: first response after reset =0.
- Minimum latency with all children ready and done one cycle after issue:
  - accept at cycle 0;
  - dn_cmd_valid at cycle 1 with handshake;
  - done at cycle 2;
  - up_rsp_valid at cycle 3.
- Any dn_done or dn_err pulse outside BUSY is ignored.

Optional Feature:
HIER_NODE_TIMEOUT_EN
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYC with done!=active, go to RESP with up_rsp_timeout=1, and set err[i] for every active child not yet done.
  - Completion and timeout in the same cycle: completion wins, timeout=0.
  - up_rsp_timeout clears on leaving RESP.
- Undefined: no counter, BUSY waits indefinitely, up_rsp_timeout tied 0.

Test Plan:
- NUM_CHILD=5, child_en=5'b11111, all ready, each done one cycle after issue, no errors → up_rsp_valid at cycle 3, err_mask=0, seq=0.
- child_en=5'b10101; child 2 holds ready low for 4 cycles; child 4 reports dn_err → dn_cmd_valid[2] held with stable data; err_mask=5'b10000, err=1.
- child_en=0 → up_rsp_valid one cycle after accept, err_mask=0; no dn_cmd_valid ever asserted.
- up_rsp_ready held low 6 cycles, then 256 back-to-back transactions with SEQ_W=8 → response fields stable while stalled; seq wraps 255→0.
- dn_done pulsed for a not-yet-issued child, and rst asserted mid-BUSY → spurious done ignored; after reset all outputs 0, up_cmd_ready=1, next seq=0.
- With HIER_NODE_TIMEOUT_EN, TIMEOUT_CYC=16, child 1 never completes → up_rsp_timeout=1 at BUSY cycle 16, err_mask bit 1 set.
